mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
MEM-stage controller sitting directly downstream of the EX/MEM pipeline register. It consumes the registered control bits, ALU result, store data and branch/jump targets. It resolves branches and jumps and issues PC redirect and flush, and runs a req/ack handshake to data memory with stall generation, timeout and alignment checks. Load data is presented to the MEM/WB register.

Parameters:
AWIDTH, 32, address width (PC, targets, dmem address)
DWIDTH, 32, data width (ALU result, store/load data)
TIMEOUT, 15, max wait cycles for dmem_ack before bus error (1..2^TWIDTH-1)
TWIDTH, 4, timeout counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
memwrin  in  1  store request (EX/MEM)
memrdin  in  1  load request (EX/MEM)
bbnein, bbeqin, bblezin, bbgtzin  in  1 each  branch-type flags
jumpin  in  1  unconditional jump
zeroin, negativein  in  1 each  ALU flags
aluoutin  in  DWIDTH  effective address
regdata2in  in  DWIDTH  store data
branaddrin  in  AWIDTH  branch target
jmpaddrin  in  AWIDTH  jump target
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write, registered
dmem_addr  out  AWIDTH  registered address
dmem_wdata  out  DWIDTH  registered store data
dmem_ack  in  1  memory completion, one cycle
dmem_rdata  in  DWIDTH  load data, valid with dmem_ack
rddataout  out  DWIDTH  captured load data, registered
rdvalidout  out  1  rddataout valid this cycle
stallout  out  1  hold IF..EX/MEM
pcsrcout  out  2  00 sequential, 01 branch, 10 jump
pctargetout  out  AWIDTH  redirect target
flushout  out  1  flush younger stages
buserrout  out  1  sticky bus error

Behaviour:
- Reset (sync): state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, rddataout=0, rdvalidout=0, buserrout=0, counter=0.
- access = memrdin | memwrin. If both are set, treat as a write (we=1). misalign = access & (aluoutin[1:0]!=0).
- States:
  - IDLE: if access & ~misalign, latch addr/wdata/we, set dmem_req=1, counter=0, go to WAIT. If misalign, no request; set buserrout and go to ERR.
  - WAIT: on dmem_ack, drop req. If it is a read, capture rddataout=dmem_rdata. Go to DONE. Without ack, counter+1; when counter==TIMEOUT, drop req, set buserrout, rddataout=0, go to ERR.
  - DONE: rdvalidout=1 if it was a read; go to IDLE.
  - ERR: rdvalidout=0; go to IDLE.
- Stall: stallout is combinational. It is 1 in IDLE when access is pending, and 1 in WAIT. It is 0 in DONE and ERR, which is the cycle the instruction leaves MEM.
- Latency: zero-wait ack (ack in the first req cycle) gives stall for 2 cycles and the instruction leaves MEM on the 3rd. k wait cycles add k.
- A non-memory instruction never stalls and passes through in 1 cycle.
- dmem_ack outside WAIT is ignored. Outputs are held stable while req=1.
- Branch taken = bbeq&zero | bbne&~zero | bblez&(zero|negative) | bbgtz&~zero&~negative.
- Redirect logic is combinational and qualified by ~stallout:
  - jumpin gives pcsrc=10, target=jmpaddrin.
  - Otherwise taken gives pcsrc=01, target=branaddrin.
  - Otherwise pcsrc=00, target=0.
  - flushout = (pcsrc!=00). Jump has priority over branch.
- A memory op combined with a branch flag redirects only in the DONE/ERR cycle.
- buserrout stays 1 until rst; later accesses still proceed.
- Reset mid-WAIT: dmem_req=0 after the reset edge and the pending access is abandoned. A late ack is ignored.

Test Plan:
- Load at addr 0x100, ack in the first req cycle with rdata=0xDEADBEEF -> dmem_req high 1 cycle with we=0, stall 2 cycles, rdvalidout=1 with rddataout=0xDEADBEEF in the 3rd cycle.
- Store 0x12345678 to 0x40, ack after 3 wait cycles -> dmem_we=1, addr/wdata stable for 4 req cycles, stall 5 cycles, rdvalidout stays 0.
- No ack -> timeout after TIMEOUT=15 cycles, req drops, buserrout=1 sticky, rddataout=0. A following load at 0x8 with immediate ack completes normally while buserrout stays 1.
- Load at addr 0x102 -> no dmem_req, buserrout=1, stall 1 cycle.
- beq with zero=1 and branaddr=0x200 -> pcsrc=01, target=0x200, flush=1. beq and jump together with jmpaddr=0x400 -> pcsrc=10, target=0x400. bgtz with negative=1 -> pcsrc=00, flush=0.
- rst asserted in the 2nd WAIT cycle, then an ack one cycle later -> req=0 after the edge, state IDLE, rdvalidout never asserts, buserrout=0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: resolves branches/jumps into a PC redirect and runs the
// data-memory req/ack handshake with stall, timeout and alignment checking.
module mem_stage_ctrl #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 15,
  parameter int TWIDTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwrin,
  input  logic              memrdin,
  input  logic              bbnein,
  input  logic              bbeqin,
  input  logic              bblezin,
  input  logic              bbgtzin,
  input  logic              jumpin,
  input  logic              zeroin,
  input  logic              negativein,
  input  logic [DWIDTH-1:0] aluoutin,
  input  logic [DWIDTH-1:0] regdata2in,
  input  logic [AWIDTH-1:0] branaddrin,
  input  logic [AWIDTH-1:0] jmpaddrin,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [AWIDTH-1:0] dmem_addr,
  output logic [DWIDTH-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DWIDTH-1:0] dmem_rdata,
  output logic [DWIDTH-1:0] rddataout,
  output logic              rdvalidout,
  output logic              stallout,
  output logic [1:0]        pcsrcout,
  output logic [AWIDTH-1:0] pctargetout,
  output logic              flushout,
  output logic              buserrout,
  output logic [1:0]        dbg_state
);

  // Memory handshake: dmem_req rises for one access and stays high, with
  // dmem_we/dmem_addr/dmem_wdata frozen, until the single-cycle dmem_ack
  // arrives or the wait budget runs out; dmem_ack is only honoured in WAIT.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            state_q;
  logic [TWIDTH-1:0] cnt_q;
  logic              rd_q;
  logic              access;
  logic              misalign;
  logic              taken;
  logic [AWIDTH-1:0] eff_addr;

  assign access   = memrdin | memwrin;
  assign misalign = access & (aluoutin[1:0] != 2'b00);
  assign eff_addr = AWIDTH'(aluoutin);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rddataout  <= '0;
      rdvalidout <= 1'b0;
      buserrout  <= 1'b0;
    end else begin
      rdvalidout <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (misalign) begin
            buserrout <= 1'b1;
            state_q   <= S_ERR;
          end else if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= memwrin;
            dmem_addr  <= eff_addr;
            dmem_wdata <= regdata2in;
            rd_q       <= ~memwrin;
            cnt_q      <= '0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            if (rd_q) rddataout <= dmem_rdata;
            rdvalidout <= rd_q;
            state_q    <= S_DONE;
          end else if (cnt_q == TWIDTH'(TIMEOUT - 1)) begin
            // Budget exhausted: this is the TIMEOUT-th request cycle without ack.
            dmem_req  <= 1'b0;
            buserrout <= 1'b1;
            rddataout <= '0;
            state_q   <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stallout = ((state_q == S_IDLE) & access) | (state_q == S_WAIT);

  assign taken = (bbeqin & zeroin) | (bbnein & ~zeroin) |
                 (bblezin & (zeroin | negativein)) |
                 (bbgtzin & ~zeroin & ~negativein);

  // Redirect only when the instruction is actually leaving MEM this cycle.
  always_comb begin
    pcsrcout    = 2'b00;
    pctargetout = '0;
    if (!stallout) begin
      if (jumpin) begin
        pcsrcout    = 2'b10;
        pctargetout = jmpaddrin;
      end else if (taken) begin
        pcsrcout    = 2'b01;
        pctargetout = branaddrin;
      end
    end
  end

  assign flushout = (pcsrcout != 2'b00);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a transaction-level model expands each
// instruction into the per-cycle outputs it must produce; one process compares.
module tb_mem_stage_ctrl;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrin, memrdin, bbnein, bbeqin, bblezin, bbgtzin, jumpin;
  logic        zeroin, negativein;
  logic [31:0] aluoutin, regdata2in, branaddrin, jmpaddrin;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, rddataout, pctargetout;
  logic        rdvalidout, stallout, flushout, buserrout;
  logic [1:0]  pcsrcout, dbg_state;

  mem_stage_ctrl #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TIMEOUT), .TWIDTH(4)) dut (
    .clk(clk), .rst(rst), .memwrin(memwrin), .memrdin(memrdin),
    .bbnein(bbnein), .bbeqin(bbeqin), .bblezin(bblezin), .bbgtzin(bbgtzin),
    .jumpin(jumpin), .zeroin(zeroin), .negativein(negativein),
    .aluoutin(aluoutin), .regdata2in(regdata2in),
    .branaddrin(branaddrin), .jmpaddrin(jmpaddrin),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rddataout(rddataout), .rdvalidout(rdvalidout), .stallout(stallout),
    .pcsrcout(pcsrcout), .pctargetout(pctargetout), .flushout(flushout),
    .buserrout(buserrout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        rdvalid;
    logic [31:0] rddata;
    logic [1:0]  pcsrc;
    logic [31:0] target;
    logic        flush;
    logic        buserr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   stall_cnt, req_cnt, rdv_cnt;

  // model of the architecturally visible held values
  logic        m_we, m_buserr;
  logic [31:0] m_addr, m_wdata, m_rddata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.we = m_we; e.addr = m_addr; e.wdata = m_wdata;
    e.rddata = m_rddata; e.buserr = m_buserr;
    return e;
  endfunction

  function automatic exp_t with_redirect(input exp_t e);
    exp_t r;
    logic tk;
    r = e;
    tk = (bbeqin & zeroin) | (bbnein & ~zeroin) | (bblezin & (zeroin | negativein)) |
         (bbgtzin & ~zeroin & ~negativein);
    if (jumpin) begin r.pcsrc = 2'b10; r.target = jmpaddrin; end
    else if (tk) begin r.pcsrc = 2'b01; r.target = branaddrin; end
    r.flush = (r.pcsrc != 2'b00);
    return r;
  endfunction

  always @(negedge clk) begin
    if (stallout) stall_cnt++;
    if (dmem_req) req_cnt++;
    if (rdvalidout) rdv_cnt++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req", 32'(dmem_req), 32'(e.req));
      chk("we", 32'(dmem_we), 32'(e.we));
      chk("addr", dmem_addr, e.addr);
      chk("wdata", dmem_wdata, e.wdata);
      chk("stall", 32'(stallout), 32'(e.stall));
      chk("rdvalid", 32'(rdvalidout), 32'(e.rdvalid));
      chk("rddata", rddataout, e.rddata);
      chk("pcsrc", 32'(pcsrcout), 32'(e.pcsrc));
      chk("target", pctargetout, e.target);
      chk("flush", 32'(flushout), 32'(e.flush));
      chk("buserr", 32'(buserrout), 32'(e.buserr));
    end
  end

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
  endtask

  task automatic clear_in();
    memwrin = 0; memrdin = 0; bbnein = 0; bbeqin = 0; bblezin = 0; bbgtzin = 0;
    jumpin = 0; zeroin = 0; negativein = 0;
    aluoutin = 0; regdata2in = 0; branaddrin = 0; jmpaddrin = 0;
    dmem_ack = 0; dmem_rdata = 32'hBAD0BAD0;
  endtask

  task automatic clear_cnts();
    stall_cnt = 0; req_cnt = 0; rdv_cnt = 0;
  endtask

  task automatic nop();
    step(with_redirect(base()));
  endtask

  // k >= 0: ack arrives after k ack-less request cycles; k < 0: never acked
  task automatic mem_op(input int k, input logic [31:0] rdata);
    exp_t e;
    logic is_rd;
    int   n;
    is_rd = ~memwrin;
    e = base(); e.stall = 1'b1;
    if (aluoutin[1:0] != 2'b00) begin
      step(e);
      m_buserr = 1'b1;
      step(with_redirect(base()));
      return;
    end
    step(e);
    m_we = memwrin; m_addr = aluoutin; m_wdata = regdata2in;
    n = (k < 0) ? TIMEOUT : k + 1;
    for (int i = 0; i < n; i++) begin
      e = base(); e.req = 1'b1; e.stall = 1'b1;
      dmem_rdata = 32'h0BAD0000 | i;
      if (k >= 0 && i == k) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
      step(e);
    end
    if (k < 0) begin m_buserr = 1'b1; m_rddata = '0; end
    else if (is_rd) m_rddata = rdata;
    e = base(); e.rdvalid = (k >= 0) && is_rd;
    step(with_redirect(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    clear_in();
    clear_cnts();
    rst = 1'b1;
    m_we = 0; m_buserr = 0; m_addr = 0; m_wdata = 0; m_rddata = 0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_rddata", rddataout, 32'd0);
    chk("rst_buserr", 32'(buserrout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nop();

    // load 0x100, zero-wait ack
    clear_in(); clear_cnts();
    memrdin = 1; aluoutin = 32'h100;
    mem_op(0, 32'hDEADBEEF);
    chk("ld_stall_cycles", stall_cnt, 32'd2);
    chk("ld_req_cycles", req_cnt, 32'd1);
    chk("ld_rdvalid_cycles", rdv_cnt, 32'd1);
    chk("ld_data", rddataout, 32'hDEADBEEF);
    clear_in(); nop();

    // store 0x12345678 to 0x40, 3 wait cycles
    clear_cnts();
    memwrin = 1; aluoutin = 32'h40; regdata2in = 32'h12345678;
    mem_op(3, 32'h0);
    chk("st_stall_cycles", stall_cnt, 32'd5);
    chk("st_req_cycles", req_cnt, 32'd4);
    chk("st_rdvalid_cycles", rdv_cnt, 32'd0);
    chk("st_we", 32'(dmem_we), 32'd1);
    clear_in(); nop();

    // timeout, then a normal load with the sticky error still set
    clear_cnts();
    memrdin = 1; aluoutin = 32'h80;
    mem_op(-1, 32'h0);
    chk("to_req_cycles", req_cnt, 32'd15);
    chk("to_buserr", 32'(buserrout), 32'd1);
    chk("to_rddata", rddataout, 32'd0);
    clear_in(); nop();
    memrdin = 1; aluoutin = 32'h8;
    mem_op(0, 32'hCAFEF00D);
    chk("after_to_data", rddataout, 32'hCAFEF00D);
    chk("after_to_buserr", 32'(buserrout), 32'd1);
    clear_in(); nop();

    // misaligned load
    clear_cnts();
    memrdin = 1; aluoutin = 32'h102;
    mem_op(0, 32'h0);
    chk("mis_stall_cycles", stall_cnt, 32'd1);
    chk("mis_req_cycles", req_cnt, 32'd0);
    clear_in(); nop();

    // branches and jumps on non-memory instructions
    bbeqin = 1; zeroin = 1; branaddrin = 32'h200; jmpaddrin = 32'h400;
    nop();
    chk("beq_pcsrc", 32'(pcsrcout), 32'd1);
    chk("beq_target", pctargetout, 32'h200);
    chk("beq_flush", 32'(flushout), 32'd1);
    jumpin = 1;
    nop();
    chk("jmp_pcsrc", 32'(pcsrcout), 32'd2);
    chk("jmp_target", pctargetout, 32'h400);
    clear_in();
    bbgtzin = 1; negativein = 1; branaddrin = 32'h200;
    nop();
    chk("bgtz_pcsrc", 32'(pcsrcout), 32'd0);
    chk("bgtz_flush", 32'(flushout), 32'd0);
    clear_in(); bbnein = 1; branaddrin = 32'h44; nop();
    clear_in(); bblezin = 1; negativein = 1; branaddrin = 32'h48; nop();
    clear_in(); bblezin = 1; branaddrin = 32'h4C; nop();
    clear_in(); bbgtzin = 1; branaddrin = 32'h50; nop();

    // load combined with beq: redirect only when leaving MEM
    clear_in(); clear_cnts();
    memrdin = 1; aluoutin = 32'h10; bbeqin = 1; zeroin = 1; branaddrin = 32'h300;
    mem_op(1, 32'hA5A5A5A5);
    clear_in();

    // load+store together behaves as a write
    memrdin = 1; memwrin = 1; aluoutin = 32'h24; regdata2in = 32'h77;
    mem_op(0, 32'h11111111);
    clear_in();

    // ack outside WAIT is ignored
    dmem_ack = 1; dmem_rdata = 32'h99999999;
    nop();
    nop();

    // reset during the 2nd WAIT cycle, then a late ack
    clear_cnts();
    memrdin = 1; aluoutin = 32'h20;
    e = base(); e.stall = 1; step(e);
    m_we = 0; m_addr = 32'h20; m_wdata = 0;
    e = base(); e.req = 1; e.stall = 1; step(e);
    rst = 1;
    e = base(); e.req = 1; e.stall = 1; step(e);
    rst = 0;
    chk("rstw_state", 32'(dbg_state), 32'd0);
    chk("rstw_req", 32'(dmem_req), 32'd0);
    m_we = 0; m_addr = 0; m_wdata = 0; m_rddata = 0; m_buserr = 0;
    clear_in();
    dmem_ack = 1; dmem_rdata = 32'h55555555;
    nop();
    nop();
    chk("rstw_rdvalid_cycles", rdv_cnt, 32'd0);
    chk("rstw_buserr", 32'(buserrout), 32'd0);
    chk("rstw_state_after", 32'(dbg_state), 32'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
